// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift_ctrl serializer.
// State encodings and the gap counter width.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int GAP_CW = 4;

endpackage

// File: rtl/shift_ctrl_piso.sv
// Parallel-in / serial-out shift register, MSB first.
// Shifts left with zero fill, so it is empty once a frame has gone out.
module shift_reg_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            unique case (1'b1)
                load:     sr <= din;
                shift_en: sr <= {sr[WIDTH-2:0], 1'b0};
                default:  sr <= sr;
            endcase
        end
    end

    assign msb = sr[WIDTH-1];

endmodule

// File: rtl/shift_ctrl.sv
// Word-to-serial controller: accepts a word, shifts it out MSB
// first, then idles GAP cycles before taking the next one.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             pause,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [GAP_CW-1:0] gcnt, gcnt_nx;
    logic              ready_q;
    logic              start_q;
    logic              done_q;
    logic              accept;
    logic              shift_en;

    assign accept   = (state == ST_IDLE) & in_valid & ready_q;
    assign shift_en = (state == ST_SHIFT) & ~pause;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gcnt_nx  = gcnt;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = ST_SHIFT;
                    cnt_nx   = CW'(WIDTH - 1);
                end
            end
            ST_SHIFT: begin
                if (!pause) begin
                    if (cnt == '0) begin
                        if (GAP > 0) begin
                            state_nx = ST_GAP;
                            gcnt_nx  = GAP_CW'(GAP - 1);
                        end else begin
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (!pause) begin
                    if (gcnt == '0) begin
                        state_nx = ST_IDLE;
                    end else begin
                        gcnt_nx = gcnt - GAP_CW'(1);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Pulses are registered from the edge that enters the bit,
    // so a paused bit never re-pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gcnt    <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            gcnt    <= gcnt_nx;
            ready_q <= (state_nx == ST_IDLE);
            start_q <= accept;
            done_q  <= shift_en & (cnt == CW'(1));
        end
    end

    shift_reg_piso #(
        .WIDTH(WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .shift_en (shift_en),
        .din      (in_data),
        .msb      (sout)
    );

    assign in_ready    = ready_q;
    assign sout_valid  = (state == ST_SHIFT);
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign busy        = (state != ST_IDLE);

endmodule
